// File: rtl/proc_pkg.sv
// Shared definitions for the basic processor: opcodes, branch codes,
// sequencer states and the instruction field layout.
package proc_pkg;

    localparam int unsigned OPC_W = 4;
    localparam int unsigned REG_W = 4;
    localparam int unsigned IMM_W = 8;
    localparam int unsigned BR_W  = 2;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h3;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h4;
    localparam logic [OPC_W-1:0] OP_LDI  = 4'h7;
    localparam logic [OPC_W-1:0] OP_BEQ  = 4'hC;
    localparam logic [OPC_W-1:0] OP_BLT  = 4'hD;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    localparam logic [BR_W-1:0] BR_NONE = 2'b00;
    localparam logic [BR_W-1:0] BR_BEQ  = 2'b01;
    localparam logic [BR_W-1:0] BR_BLT  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Instruction layout: [15:12] opcode, [11:8] ra, [7:4] rb, [3:0] rc; imm = {rb, rc}
    typedef struct packed {
        logic [OPC_W-1:0] opcd;
        logic [REG_W-1:0] ra;
        logic [REG_W-1:0] rb;
        logic [REG_W-1:0] rc;
    } instr_t;

    // True for opcodes that execute (HALT is handled separately)
    function automatic logic op_legal(input logic [OPC_W-1:0] op);
        case (op)
            OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_LDI, OP_BEQ, OP_BLT: op_legal = 1'b1;
            default:                op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter: clear on start, advance by 1 or by 1 + signed offset.
module pc_unit
    import proc_pkg::*;
#(
    parameter int unsigned PC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    input  logic             taken,
    input  logic [REG_W-1:0] off,
    output logic [PC_W-1:0]  pc
);

    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] pc_nxt;

    // Sign-extend the branch offset and form the next sequential/branch pc (wraps naturally)
    always_comb begin
        off_ext = PC_W'($signed(off));
        pc_nxt  = pc + PC_W'(1) + (taken ? off_ext : '0);
    end

    // PC register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
        end else if (clr) begin
            pc <= '0;
        end else if (adv) begin
            pc <= pc_nxt;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: fetches over req/ack, holds the instruction
// register, opens a one-cycle execute window and resolves BEQ/BLT.
module instr_sequencer
    import proc_pkg::*;
#(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned IW    = 16,
    parameter int unsigned RET_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [IW-1:0]    imem_rdata,
    output logic [3:0]       opcd,
    output logic [3:0]       ra,
    output logic [3:0]       rb,
    output logic [3:0]       rc,
    output logic [7:0]       imm,
    input  logic [1:0]       branch,
    input  logic             alu_zero,
    input  logic             alu_neg,
    output logic             exec_en,
    output logic [PC_W-1:0]  pc,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [RET_W-1:0] retired
);

    state_t state;
    state_t state_nxt;
    instr_t ir;
    logic   ill_nxt;
    logic   clr_pc;
    logic   adv_pc;
    logic   taken;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, pc control and halt cause
    always_comb begin
        state_nxt = state;
        ill_nxt   = illegal;
        clr_pc    = 1'b0;
        adv_pc    = 1'b0;
        taken     = ((branch == BR_BEQ) && alu_zero) || ((branch == BR_BLT) && alu_neg);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_FETCH;
                    clr_pc    = 1'b1;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (ir.opcd == OP_HALT) begin
                    state_nxt = ST_HALT;
                    ill_nxt   = 1'b0;
                end else if (!op_legal(ir.opcd)) begin
                    state_nxt = ST_HALT;
                    ill_nxt   = 1'b1;
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                adv_pc    = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status outputs registered from the next state so they line up with the state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_req <= 1'b0;
            exec_en  <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            imem_req <= (state_nxt == ST_FETCH);
            exec_en  <= (state_nxt == ST_EXEC);
            busy     <= (state_nxt != ST_IDLE) && (state_nxt != ST_HALT);
            halted   <= (state_nxt == ST_HALT);
            illegal  <= ill_nxt;
        end
    end

    // Instruction register, loaded only on the acknowledged fetch cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir <= '0;
        end else if ((state == ST_FETCH) && imem_ack) begin
            ir <= instr_t'(imem_rdata);
        end
    end

    // Retired-instruction counter, one per execute window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired <= '0;
        end else if (state == ST_EXEC) begin
            retired <= retired + RET_W'(1);
        end
    end

    pc_unit #(
        .PC_W (PC_W)
    ) u_pc (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_pc),
        .adv   (adv_pc),
        .taken (taken),
        .off   (ir.rc),
        .pc    (pc)
    );

    assign imem_addr = pc;
    assign opcd      = ir.opcd;
    assign ra        = ir.ra;
    assign rb        = ir.rb;
    assign rc        = ir.rc;
    assign imm       = {ir.rb, ir.rc};

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle fetch/decode/execute sequencer for the basic processor. It fetches 16-bit instructions from instruction memory over a req/ack handshake and presents the opcode to the registered opcode decoder. It then opens a one-cycle execute window that qualifies register-file writes, and resolves BEQ/BLT using ALU flags to update the PC. It sits between instruction memory, the opcode decoder and the datapath.

Parameters:
PC_W, 8, program counter / instruction address width
IW, 16, instruction width (fields fixed below; IW must be 16)
RET_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  begin execution from pc=0; sampled only in IDLE
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch address (= pc)
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  IW  fetched instruction
opcd  out  4  ir[15:12] to opcode decoder
ra  out  4  ir[11:8]
rb  out  4  ir[7:4]
rc  out  4  ir[3:0]
imm  out  8  ir[7:0] (LDI immediate)
branch  in  2  from decoder: 01 BEQ, 10 BLT, 00 none
alu_zero  in  1  ALU result zero (valid in EXEC)
alu_neg  in  1  ALU result negative (valid in EXEC)
exec_en  out  1  execute window; datapath gates decoder we with it
pc  out  PC_W  current program counter
busy  out  1  state not IDLE/HALT
halted  out  1  HALT or illegal opcode reached
illegal  out  1  halt caused by undefined opcode
retired  out  RET_W  count of executed instructions

Behaviour:
- Reset (async, rst=0): state=IDLE, pc=0, ir=0, retired=0; imem_req, exec_en, busy, halted and illegal are all 0 immediately, including mid-fetch or mid-exec.
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- IDLE:
  - start=1 -> FETCH with pc=0, retired unchanged.
  - start is ignored in every other state.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until imem_ack is sampled 1.
  - On ack: ir<=imem_rdata, then DECODE; imem_req drops the next cycle.
  - Zero-wait ack (ack in the first FETCH cycle) is legal.
- DECODE (1 cycle):
  - opcd is driven from ir; the registered decoder updates its outputs at the end of this cycle.
  - opcd=1111 (HALT) -> HALT, illegal=0.
  - opcd not in {0000,0001,0010,0011,0100,0111,1100,1101,1111} -> HALT, illegal=1.
  - Otherwise -> EXEC.
- EXEC (1 cycle):
  - exec_en=1; retired<=retired+1, wrapping modulo 2^RET_W.
  - taken = (branch==01 & alu_zero) | (branch==10 & alu_neg).
  - pc <= taken ? pc+1+sext(rc) : pc+1, modulo 2^PC_W (wraps 255->0 at PC_W=8).
  - Then -> FETCH.
- HALT: halted=1, pc frozen; leave only via reset.
- opcd/ra/rb/rc/imm are valid from DECODE through EXEC and hold the last ir in all other states.
- Minimum throughput is 3 cycles/instruction; each FETCH wait cycle adds 1.
- The HALT instruction is not counted in retired.

Decomposition:
- Shared package proc_pkg: opcode constants (OP_NOP..OP_BLT, OP_HALT), branch codes (BR_NONE/BEQ/BLT), state encoding, instruction field positions.
- One natural sub-module: pc_unit (pc register, increment, sign-extended offset add, wrap).

Test Plan:
- Reset then start, memory {0:0x7105 LDI, 1:0x1123 ADD, 2:0xF000} with zero-wait ack -> pc sequence 0,1,2; exec_en pulses every 3rd cycle (2 pulses); halted=1, illegal=0, retired=2.
- Fetch with 3-cycle ack delay -> imem_req held 3 cycles with imem_addr stable; ir captured only on ack cycle.
- BEQ at pc=4, rc=4'hE (-2), alu_zero=1 in EXEC -> next pc=3; with alu_zero=0 -> next pc=5.
- BLT at pc=255, rc=1, alu_neg=1 -> next pc=1 (wrap); alu_neg=0 -> next pc=0.
- Opcode 0101 at pc=2 -> HALT after DECODE, illegal=1, exec_en never asserted for it, retired unchanged.
- rst=0 asserted mid-FETCH (imem_req=1) -> imem_req=0 and busy=0 the same cycle; start pulse afterwards restarts at pc=0.
